// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera window packer: FSM states, FIFO word
// flag positions, decimation decode and FIFO word width derivation.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_TRUNC  = 2'd2,
    ST_SKIP   = 2'd3
  } state_t;

  // Flag bit offsets counted from the top of the data field: word = {sop, eop, err, data}
  localparam int FLD_ERR = 0;
  localparam int FLD_EOP = 1;
  localparam int FLD_SOP = 2;
  localparam int NFLAGS  = 3;

  typedef struct packed {
    logic       valid;
    logic [2:0] step;
    logic [1:0] mask;
  } dec_t;

  function automatic dec_t dec_decode(input logic [1:0] dec);
    dec_t d;
    d.valid = (dec != 2'd3);
    case (dec)
      2'd0:    begin d.step = 3'd1; d.mask = 2'b00; end
      2'd1:    begin d.step = 3'd2; d.mask = 2'b01; end
      2'd2:    begin d.step = 3'd4; d.mask = 2'b11; end
      default: begin d.step = 3'd1; d.mask = 2'b00; end
    endcase
    return d;
  endfunction

  function automatic int fw_calc(input int nch, input int out_bits);
    return nch * out_bits + NFLAGS;
  endfunction

endpackage

// File: rtl/cam_chan_conv.sv
// Per-channel width reduction: truncate to MSBs, or round-half-up with
// saturation to all-ones when rounding would carry out of the channel.
module cam_chan_conv #(
  parameter int IN_BITS  = 12,
  parameter int OUT_BITS = 8,
  parameter int ROUND    = 0
) (
  input  logic [IN_BITS-1:0]  i_chan,
  output logic [OUT_BITS-1:0] o_chan
);

  localparam int DROP = IN_BITS - OUT_BITS;

  generate
    if (DROP == 0) begin : g_pass
      assign o_chan = i_chan;
    end else if (ROUND == 0) begin : g_trunc
      assign o_chan = OUT_BITS'(i_chan >> DROP);
    end else begin : g_round
      localparam logic [IN_BITS:0] HALF = (IN_BITS+1)'(1) << (DROP - 1);
      logic [IN_BITS:0] w_sum;
      assign w_sum  = {1'b0, i_chan} + HALF;
      assign o_chan = w_sum[IN_BITS] ? '1 : OUT_BITS'(w_sum >> DROP);
    end
  endgenerate

endmodule

// File: rtl/cam_window_packer.sv
// Pixel-clock front end: crops and decimates the debayered stream and emits
// framed {sop, eop, err, data} words to the dual-clock FIFO write port.
module cam_window_packer
  import cam_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int IN_BITS  = 12,
  parameter int OUT_BITS = 8,
  parameter int CW       = 12,
  parameter int ROUND    = 0,
  parameter int FW       = fw_calc(NCH, OUT_BITS)
) (
  input  logic                   CAMERA_PIXCLK,
  input  logic                   reset_n,
  input  logic [NCH*IN_BITS-1:0] pix_data,
  input  logic                   pix_valid,
  input  logic                   pix_fval,
  input  logic                   pix_lval,
  input  logic [CW-1:0]          cfg_x0,
  input  logic [CW-1:0]          cfg_y0,
  input  logic [CW-1:0]          cfg_w,
  input  logic [CW-1:0]          cfg_h,
  input  logic [1:0]             cfg_dec,
  output logic [FW-1:0]          fifo_wdata,
  output logic                   fifo_wreq,
  input  logic                   fifo_wfull,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [15:0]            drop_cnt
);

  localparam int DW = NCH * OUT_BITS;
  localparam logic [CW-1:0] CMAX = '1;

  state_t        r_state, w_state_nx;
  logic          r_fval_d, r_lval_d, r_sop_done;
  logic [CW-1:0] r_x, r_y, r_x0, r_y0, r_w, r_h;
  logic [1:0]    r_mask;
  logic [2:0]    r_step;

  dec_t          w_cdec;
  logic          w_rise, w_cfg_ok;
  logic [CW:0]   w_dx, w_dy, w_step;
  logic          w_inx, w_iny, w_qual, w_sop, w_eop;
  logic [DW-1:0] w_conv;
  logic          w_wreq, w_done, w_err, w_drop, w_sop_set;
  logic [FW-1:0] w_wdata;

  assign w_cdec   = dec_decode(cfg_dec);
  assign w_rise   = pix_fval & ~r_fval_d;
  assign w_cfg_ok = w_cdec.valid && (cfg_w != '0) && (cfg_h != '0) &&
                    ((cfg_w[1:0] & w_cdec.mask) == 2'b00) &&
                    ((cfg_h[1:0] & w_cdec.mask) == 2'b00);

  // Offsets are formed one bit wider than the counters so window ends never wrap
  assign w_step = {{(CW-2){1'b0}}, r_step};
  assign w_dx   = {1'b0, r_x} - {1'b0, r_x0};
  assign w_dy   = {1'b0, r_y} - {1'b0, r_y0};
  assign w_inx  = (r_x >= r_x0) && (w_dx < {1'b0, r_w});
  assign w_iny  = (r_y >= r_y0) && (w_dy < {1'b0, r_h});
  assign w_qual = pix_valid && pix_lval && w_inx && w_iny &&
                  ((w_dx[1:0] & r_mask) == 2'b00) && ((w_dy[1:0] & r_mask) == 2'b00);
  assign w_sop  = (w_dx == '0) && (w_dy == '0);
  assign w_eop  = (w_dx == ({1'b0, r_w} - w_step)) && (w_dy == ({1'b0, r_h} - w_step));

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_chan
      cam_chan_conv #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS),
        .ROUND   (ROUND)
      ) u_conv (
        .i_chan(pix_data[c*IN_BITS +: IN_BITS]),
        .o_chan(w_conv[c*OUT_BITS +: OUT_BITS])
      );
    end
  endgenerate

  // fval history resets high so a frame already running at reset release is not seen as a rise
  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_fval_d <= 1'b1;
      r_lval_d <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      r_fval_d <= pix_fval;
      r_lval_d <= pix_lval;
      if (!pix_lval)
        r_x <= '0;
      else if (pix_valid && r_x != CMAX)
        r_x <= r_x + CW'(1);
      if (!pix_fval)
        r_y <= '0;
      else if (r_lval_d && !pix_lval && r_y != CMAX)
        r_y <= r_y + CW'(1);
    end
  end

  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_x0       <= '0;
      r_y0       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_mask     <= '0;
      r_step     <= 3'd1;
      r_sop_done <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_rise) begin
        r_x0   <= cfg_x0;
        r_y0   <= cfg_y0;
        r_w    <= cfg_w;
        r_h    <= cfg_h;
        r_mask <= w_cdec.mask;
        r_step <= w_cdec.step;
      end
      if (r_state == ST_IDLE)
        r_sop_done <= 1'b0;
      else if (w_sop_set)
        r_sop_done <= 1'b1;
    end
  end

  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nx;
  end

  // A written EOP wins over a simultaneous fval fall; an unwritten packet just drops
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_rise)
          w_state_nx = w_cfg_ok ? ST_ACTIVE : ST_SKIP;
      ST_ACTIVE:
        if (w_qual && !fifo_wfull && w_eop)
          w_state_nx = ST_SKIP;
        else if (w_qual && fifo_wfull)
          w_state_nx = r_sop_done ? ST_TRUNC : ST_SKIP;
        else if (!pix_fval)
          w_state_nx = (r_sop_done || (w_qual && w_sop)) ? ST_TRUNC : ST_IDLE;
      ST_TRUNC:
        if (!fifo_wfull)
          w_state_nx = pix_fval ? ST_SKIP : ST_IDLE;
      ST_SKIP:
        if (!pix_fval)
          w_state_nx = ST_IDLE;
      default:
        w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wreq    = 1'b0;
    w_wdata   = '0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_drop    = 1'b0;
    w_sop_set = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rise && !w_cfg_ok) begin
          w_err  = 1'b1;
          w_drop = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_qual && !fifo_wfull) begin
          w_wreq               = 1'b1;
          w_wdata[DW+FLD_SOP]  = w_sop;
          w_wdata[DW+FLD_EOP]  = w_eop;
          w_wdata[DW-1:0]      = w_conv;
          w_done               = w_eop;
          w_sop_set            = w_sop;
        end else if (w_qual || !pix_fval) begin
          w_drop = !r_sop_done;
        end
      end
      ST_TRUNC: begin
        if (!fifo_wfull) begin
          w_wreq              = 1'b1;
          w_wdata[DW+FLD_EOP] = 1'b1;
          w_wdata[DW+FLD_ERR] = 1'b1;
          w_err               = 1'b1;
          w_drop              = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wreq  <= 1'b0;
      fifo_wdata <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      fifo_wreq  <= w_wreq;
      fifo_wdata <= w_wdata;
      frame_done <= w_done;
      frame_err  <= w_err;
      if (w_drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_window_packer.sv
// Randomized bench for cam_window_packer: truncating and rounding instances share
// stimulus and are compared against a frame-level pixel-walk reference model.
module tb_cam_window_packer;

  localparam int NCH = 3, IN_BITS = 12, OUT_BITS = 8, CW = 12, FW = 27;
  localparam logic [26:0] ERR_WORD = 27'h3000000;

  logic        pixClk = 1'b0;
  logic        resetN;
  logic [35:0] pixData;
  logic        pixValid, pixFval, pixLval, fifoWfull;
  logic [11:0] cfgX0, cfgY0, cfgW, cfgH;
  logic [1:0]  cfgDec;
  logic [26:0] wdata0, wdata1;
  logic        wreq0, wreq1, done0, done1, err0, err1;
  logic [15:0] drop0, drop1;

  int          checkCount = 0;
  int          errorCount = 0;
  int          doneSeen, errSeen, expDrop, fullLeft;
  logic [26:0] gotQ[$], gotQr[$], expQ[$], expQr[$];
  logic [35:0] fixedData;
  bit          useFixed;

  always #5 pixClk = ~pixClk;

  cam_window_packer #(.NCH(NCH), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CW(CW), .ROUND(0)) dut (
    .CAMERA_PIXCLK(pixClk), .reset_n(resetN), .pix_data(pixData), .pix_valid(pixValid),
    .pix_fval(pixFval), .pix_lval(pixLval), .cfg_x0(cfgX0), .cfg_y0(cfgY0), .cfg_w(cfgW),
    .cfg_h(cfgH), .cfg_dec(cfgDec), .fifo_wdata(wdata0), .fifo_wreq(wreq0),
    .fifo_wfull(fifoWfull), .frame_done(done0), .frame_err(err0), .drop_cnt(drop0));

  cam_window_packer #(.NCH(NCH), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CW(CW), .ROUND(1)) dutR (
    .CAMERA_PIXCLK(pixClk), .reset_n(resetN), .pix_data(pixData), .pix_valid(pixValid),
    .pix_fval(pixFval), .pix_lval(pixLval), .cfg_x0(cfgX0), .cfg_y0(cfgY0), .cfg_w(cfgW),
    .cfg_h(cfgH), .cfg_dec(cfgDec), .fifo_wdata(wdata1), .fifo_wreq(wreq1),
    .fifo_wfull(fifoWfull), .frame_done(done1), .frame_err(err1), .drop_cnt(drop1));

  always @(negedge pixClk) begin
    if (wreq0) gotQ.push_back(wdata0);
    if (wreq1) gotQr.push_back(wdata1);
    if (done0) doneSeen++;
    if (err0)  errSeen++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] truncCh(input int v);
    return 8'(v / 16);
  endfunction

  function automatic logic [7:0] roundCh(input int v);
    int r;
    r = (v + 8) / 16;
    if (r > 255) r = 255;
    return 8'(r);
  endfunction

  function automatic logic [11:0] randChan();
    case ($urandom_range(0, 7))
      0: return 12'h7F8;
      1: return 12'hFF9;
      2: return 12'h7F7;
      3: return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic tick();
    fifoWfull = (fullLeft > 0);
    if (fullLeft > 0) fullLeft--;
    @(negedge pixClk);
  endtask

  task automatic applyStimulus(input string tag, input int fw, input int fh, input int linesSent,
                               input int x0, input int y0, input int w, input int h, input int dec,
                               input int fullAfter, input int resetLine, input bit dropOnLast);
    int d, qualCnt, expDone, expErr;
    bit cfgOk, q, rstHappened;
    logic [35:0] px;
    logic [26:0] clean[$], cleanR[$];
    logic [26:0] wd, wr;
    d = 1 << dec;
    cfgOk = (dec != 3) && (w > 0) && (h > 0) && (w % d == 0) && (h % d == 0);
    qualCnt = 0; rstHappened = 0; fullLeft = 0;
    gotQ.delete(); gotQr.delete(); doneSeen = 0; errSeen = 0;
    cfgX0 = 12'(x0); cfgY0 = 12'(y0); cfgW = 12'(w); cfgH = 12'(h); cfgDec = 2'(dec);
    pixFval = 0; pixLval = 0; pixValid = 0;
    repeat (2) tick();
    pixFval = 1;
    tick();
    cfgX0 = 12'($urandom); cfgY0 = 12'($urandom); cfgW = 12'($urandom);
    cfgH = 12'($urandom); cfgDec = 2'($urandom);
    tick();
    for (int y = 0; y < linesSent; y++) begin
      for (int x = 0; x < fw; x++) begin
        if ($urandom_range(0, 3) == 0) begin
          pixLval = 1; pixValid = 0;
          tick();
        end
        px = useFixed ? fixedData : {randChan(), randChan(), randChan()};
        pixLval = 1; pixValid = 1; pixData = px;
        q = cfgOk && x >= x0 && x < x0 + w && y >= y0 && y < y0 + h &&
            ((x - x0) % d == 0) && ((y - y0) % d == 0);
        if (q) begin
          wd = 27'(0); wr = 27'(0);
          wd[26] = (x == x0 && y == y0);
          wd[25] = (x == x0 + w - d && y == y0 + h - d);
          wr[26:25] = wd[26:25];
          for (int c = 0; c < NCH; c++) begin
            wd[c*8 +: 8] = truncCh(int'(px[c*12 +: 12]));
            wr[c*8 +: 8] = roundCh(int'(px[c*12 +: 12]));
          end
          clean.push_back(wd); cleanR.push_back(wr);
          if (fullAfter >= 0 && qualCnt == fullAfter) fullLeft = 10;
          qualCnt++;
        end
        if (dropOnLast && y == linesSent - 1 && x == fw - 1) pixFval = 0;
        tick();
        if (y == resetLine && x == fw / 2) begin
          resetN = 0;
          #1;
          checkOutput({tag, ":rst_wreq"}, 64'(wreq0), 64'd0);
          checkOutput({tag, ":rst_wdata"}, 64'(wdata0), 64'd0);
          checkOutput({tag, ":rst_done"}, 64'(done0), 64'd0);
          checkOutput({tag, ":rst_err"}, 64'(err0), 64'd0);
          checkOutput({tag, ":rst_drop"}, 64'(drop0), 64'd0);
          @(negedge pixClk);
          resetN = 1;
          rstHappened = 1;
          gotQ.delete(); gotQr.delete(); doneSeen = 0; errSeen = 0; expDrop = 0;
        end
      end
      pixLval = 0; pixValid = 0;
      repeat (3) tick();
    end
    pixFval = 0; pixLval = 0; pixValid = 0;
    repeat (20) tick();

    expQ.delete(); expQr.delete(); expDone = 0; expErr = 0;
    if (!rstHappened) begin
      expQ = clean; expQr = cleanR;
      if (!cfgOk) begin
        expErr = 1; expDrop++;
      end else if (fullAfter >= 0 && expQ.size() > fullAfter) begin
        while (expQ.size() > fullAfter) begin void'(expQ.pop_back()); void'(expQr.pop_back()); end
        expQ.push_back(ERR_WORD); expQr.push_back(ERR_WORD);
        expErr = 1; expDrop++;
      end else if (expQ.size() == 0) begin
        expDrop++;
      end else if (!expQ[expQ.size()-1][25]) begin
        expQ.push_back(ERR_WORD); expQr.push_back(ERR_WORD);
        expErr = 1; expDrop++;
      end else begin
        expDone = 1;
      end
    end

    checkOutput({tag, ":nwords"}, 64'(gotQ.size()), 64'(expQ.size()));
    checkOutput({tag, ":nwordsR"}, 64'(gotQr.size()), 64'(expQr.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < gotQ.size())  checkOutput($sformatf("%s:w%0d", tag, i), 64'(gotQ[i]), 64'(expQ[i]));
      if (i < gotQr.size()) checkOutput($sformatf("%s:wR%0d", tag, i), 64'(gotQr[i]), 64'(expQr[i]));
    end
    checkOutput({tag, ":done"}, 64'(doneSeen), 64'(expDone));
    checkOutput({tag, ":err"}, 64'(errSeen), 64'(expErr));
    checkOutput({tag, ":drop"}, 64'(drop0), 64'(expDrop));
    checkOutput({tag, ":dropR"}, 64'(drop1), 64'(expDrop));
  endtask

  initial begin
    int fw, fh, dec, d, w, h, x0, y0, fa, nw;
    resetN = 0; pixData = '0; pixValid = 0; pixFval = 0; pixLval = 0; fifoWfull = 0;
    cfgX0 = '0; cfgY0 = '0; cfgW = '0; cfgH = '0; cfgDec = '0;
    useFixed = 0; fixedData = '0; expDrop = 0; fullLeft = 0;
    repeat (3) @(negedge pixClk);
    checkOutput("reset:wreq", 64'(wreq0), 64'd0);
    checkOutput("reset:wdata", 64'(wdata0), 64'd0);
    checkOutput("reset:done", 64'(done0), 64'd0);
    checkOutput("reset:err", 64'(err0), 64'd0);
    checkOutput("reset:drop", 64'(drop0), 64'd0);
    resetN = 1;
    repeat (2) @(negedge pixClk);

    applyStimulus("clean", 16, 8, 8, 2, 1, 8, 4, 0, -1, -1, 0);
    applyStimulus("decim", 16, 8, 8, 0, 0, 16, 8, 1, -1, -1, 0);

    useFixed = 1;
    fixedData = {12'h7F7, 12'hFF9, 12'h7F8};
    applyStimulus("round", 4, 1, 1, 0, 0, 4, 1, 0, -1, -1, 0);
    checkOutput("round:data", (gotQr.size() > 0) ? 64'(gotQr[0][23:0]) : 64'hDEAD, 64'h7FFF80);
    checkOutput("trunc:data", (gotQ.size() > 0) ? 64'(gotQ[0][23:0]) : 64'hDEAD, 64'h7FFF7F);
    useFixed = 0;

    applyStimulus("ovfl", 16, 8, 8, 2, 1, 8, 4, 0, 5, -1, 0);
    applyStimulus("short", 16, 8, 3, 2, 1, 8, 4, 0, -1, -1, 0);
    applyStimulus("badw", 16, 8, 8, 0, 0, 7, 4, 1, -1, -1, 0);
    applyStimulus("baddec", 16, 8, 8, 0, 0, 8, 4, 3, -1, -1, 0);
    applyStimulus("eopfall", 16, 8, 8, 8, 4, 8, 4, 0, -1, -1, 1);
    applyStimulus("rstmid", 16, 8, 8, 2, 1, 8, 4, 0, -1, 3, 0);
    applyStimulus("afterrst", 16, 8, 8, 2, 1, 8, 4, 0, -1, -1, 0);

    for (int n = 0; n < 6; n++) begin
      fw  = $urandom_range(4, 16);
      fh  = $urandom_range(4, 8);
      dec = $urandom_range(0, 2);
      d   = 1 << dec;
      w   = d * $urandom_range(1, fw / d);
      h   = d * $urandom_range(1, fh / d);
      x0  = $urandom_range(0, fw - w);
      y0  = $urandom_range(0, fh - h);
      nw  = (w / d) * (h / d);
      fa  = (nw > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, nw - 1) : -1;
      applyStimulus($sformatf("rand%0d", n), fw, fh, fh, x0, y0, w, h, dec, fa, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/cam_window_packer.md
# cam_window_packer

Pixel-clock-domain front end that turns the debayered pixel stream into framed FIFO write words for the clock-crossing FIFO, replacing the fixed-geometry write logic. It adds:
- runtime cropping and power-of-two decimation;
- configurable channel count and bit widths;
- optional rounding;
- short-frame and overflow handling that always closes a started packet with an error-tagged EOP word.

It sits between the Bayer-to-RGB converter and the write port of the dual-clock FIFO.

## Interface
Parameters:
- NCH, 3: colour channels per pixel
- IN_BITS, 12: bits per input channel
- OUT_BITS, 8: bits per output channel (must be ≤ IN_BITS)
- CW, 12: coordinate/counter width; maximum frame dimension is 2^CW − 1
- ROUND, 0: 0 = truncate to MSBs; 1 = round-half-up with saturation
- FW, NCH*OUT_BITS+3: derived FIFO word width

Ports:
- CAMERA_PIXCLK, in, 1: clock
- reset_n, in, 1: reset; asynchronous, active-low
- pix_data, in, NCH*IN_BITS: channel 0 in the LSBs
- pix_valid, in, 1: pix_data is valid this cycle
- pix_fval, in, 1: frame valid
- pix_lval, in, 1: line valid
- cfg_x0, cfg_y0, in, CW each: crop origin
- cfg_w, cfg_h, in, CW each: crop size in input pixels
- cfg_dec, in, 2: decimation D; 0→1, 1→2, 2→4, 3→reserved (treated as error)
- fifo_wdata, out, FW: word layout {sop, eop, err, data}
- fifo_wreq, out, 1: FIFO write request
- fifo_wfull, in, 1: FIFO full
- frame_done, out, 1: one-cycle pulse when a clean EOP is written
- frame_err, out, 1: one-cycle pulse when an error EOP is written or a frame is rejected
- drop_cnt, out, 16: saturating count of errored or rejected frames

## Operation
- **Configuration capture:** cfg_* is latched on the pix_fval rising edge and held for the whole frame.
- **Config validity:** cfg_w and cfg_h must be non-zero multiples of D, and cfg_dec must not be 3. An invalid config rejects the frame: frame_err pulses, drop_cnt increments, the FSM enters SKIP, and nothing is written.
- **Coordinate counters:**
  - x increments on each pix_valid while pix_lval is high, and clears when pix_lval is low.
  - y increments on each pix_lval falling edge, and clears when pix_fval is low.
  - Both counters saturate at 2^CW − 1.
- **Pixel selection:** a pixel qualifies when x0 ≤ x < x0+w, y0 ≤ y < y0+h, and both (x−x0) and (y−y0) are multiples of D (low bits zero).
- **Packet markers:**
  - sop = first qualifying pixel, i.e. (x0, y0).
  - eop = (x0+w−D, y0+h−D).
  - All compares use CW+1 bits so they cannot overflow.
- **Channel conversion:**
  - ROUND = 0: keep the top OUT_BITS of each channel.
  - ROUND = 1: add 1 at bit IN_BITS−OUT_BITS−1, then saturate to all-ones. When IN_BITS = OUT_BITS, pass the value through unchanged.
- **FSM states:**
  - IDLE: on a pix_fval rise, go to ACTIVE, or to SKIP if the config is invalid.
  - ACTIVE:
    - A qualifying pixel with fifo_wfull low is written.
    - Writing the EOP word goes to SKIP and pulses frame_done.
    - A qualifying pixel with fifo_wfull high goes to TRUNC; if the SOP was never written, go to SKIP instead and count the drop.
    - pix_fval falling before the EOP goes to TRUNC if the SOP was written; otherwise go to IDLE and count the drop.
  - TRUNC: on the first cycle with fifo_wfull low, write {0, 1, 1, 0}, pulse frame_err, increment drop_cnt, then go to SKIP if pix_fval is high, or IDLE if it is low.
  - SKIP: wait for pix_fval to go low, then go to IDLE.
- **Reset mid-frame:** all state clears. After reset, the block waits for the next pix_fval rising edge, so a frame already in progress is never emitted.

## Timing
- Reset values: fifo_wreq = 0, fifo_wdata = 0, frame_done = 0, frame_err = 0, drop_cnt = 0, FSM = IDLE.
- Latency: one cycle from a qualifying pix_valid to fifo_wreq, with the data registered.
- The full check is made on fifo_wfull in the cycle the pixel arrives. fifo_wreq is never asserted while fifo_wfull was high in that cycle.
- A pix_fval fall and an EOP pixel arriving in the same cycle count as a clean EOP.
- frame_done and frame_err pulse in the same cycle as the matching fifo_wreq. For a rejected frame, frame_err pulses one cycle after the pix_fval rise.
- Throughput: one word per cycle, no bubbles.

## Structure
- Shared package cam_pkg holds:
  - the FSM state enum;
  - the bit positions of the FIFO word fields (sop, eop, err);
  - the cfg_dec decode function;
  - the FW derivation function.
- One sub-module, cam_chan_conv, performs the per-channel truncate/round/saturate and is instantiated NCH times.

## Test plan
- **Clean frame:** 16×8 input, crop (2,1,8,4), D=1 → 32 words; SOP on the first, EOP on the 32nd; frame_done pulses once; err = 0 throughout.
- **Decimation:** same frame, crop (0,0,16,8), D=2 → 32 words taken from even x and even y; EOP from input pixel (14,6).
- **Rounding:** ROUND=1, IN_BITS=12, OUT_BITS=8; input channel 0x7F8 → 0x80, 0xFF9 → 0xFF (saturated), 0x7F7 → 0x7F.
- **Overflow:** fifo_wfull forced high after word 5 for 10 cycles → exactly 5 data words, then one {eop=1, err=1} word once full drops; frame_err pulses; drop_cnt = 1; nothing more is written until the next frame.
- **Short frame:** pix_fval drops after 2 of 4 crop lines → error EOP written, drop_cnt increments. In a separate run, cfg_w = 7 with D=2 → no writes and frame_err pulses.
- **Reset mid-frame:** reset_n pulsed low during line 3 → outputs return to reset values; the next full frame produces a normal 32-word packet.
